// File: rtl/sys_ctrl_rx_if.sv
// Bus bundle between the RX-side command controller and its surroundings:
// synchronized RX bytes, register file, ALU and TX FIFO.
interface sys_ctrl_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [DATA_WIDTH-1:0]   RdData;
  logic                    RdData_Valid;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    OUT_Valid;
  logic                    FIFO_FULL;
  logic [ADDR_WIDTH-1:0]   ADDR;
  logic                    WrEn;
  logic [DATA_WIDTH-1:0]   WrData;
  logic                    RdEn;
  logic                    ALU_EN;
  logic [FUN_WIDTH-1:0]    ALU_FUN;
  logic                    CLK_EN;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
    output ADDR, WrEn, WrData, RdEn, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
    input  ADDR, WrEn, WrData, RdEn, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
  );
endinterface

// File: rtl/sys_ctrl_rx.sv
// Byte-serial command-frame parser: drives RF write/read and ALU start, then
// returns read data / ALU results byte-wise to the TX FIFO with a bounded wait.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  IDLE     | waiting for an opcode byte (AA/BB/CC/DD), others dropped
//  WR_ADDR  | AA frame: waiting for address byte
//  WR_DATA  | AA frame: waiting for data byte, then one WrEn pulse
//  RD_ADDR  | BB frame: waiting for address byte, then one RdEn pulse
//  RD_WAIT  | waiting for RdData_Valid, bounded by the response timer
//  OPA      | CC frame: waiting for operand A (written to OPA_ADDR)
//  OPB      | CC frame: waiting for operand B (written to OPB_ADDR)
//  FUN      | CC/DD frame: waiting for function byte, then ALU_EN pulse
//  ALU_WAIT | waiting for OUT_Valid with CLK_EN held, bounded by the timer
//  TX_LO    | sending low result byte when the FIFO has room
//  TX_HI    | sending high result byte when the FIFO has room
module sys_ctrl_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int FUN_WIDTH   = 4,
  parameter int OPA_ADDR    = 0,
  parameter int OPB_ADDR    = 1,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RST,
  sys_ctrl_rx_if.master bus
);
  localparam int CNT_WIDTH = $clog2(RSP_TIMEOUT + 1);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WR_ADDR  = 4'd1;
  localparam logic [3:0] WR_DATA  = 4'd2;
  localparam logic [3:0] RD_ADDR  = 4'd3;
  localparam logic [3:0] RD_WAIT  = 4'd4;
  localparam logic [3:0] OPA      = 4'd5;
  localparam logic [3:0] OPB      = 4'd6;
  localparam logic [3:0] FUN      = 4'd7;
  localparam logic [3:0] ALU_WAIT = 4'd8;
  localparam logic [3:0] TX_LO    = 4'd9;
  localparam logic [3:0] TX_HI    = 4'd10;

  localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'('hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'('hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'('hCC);
  localparam logic [DATA_WIDTH-1:0] OP_FUN = DATA_WIDTH'('hDD);
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(RSP_TIMEOUT);

  logic [3:0]              state;
  logic [CNT_WIDTH-1:0]    wait_cnt;
  logic [2*DATA_WIDTH-1:0] result;
  logic                    single_byte;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      result        <= '0;
      single_byte   <= 1'b0;
      bus.ADDR      <= '0;
      bus.WrEn      <= 1'b0;
      bus.WrData    <= '0;
      bus.RdEn      <= 1'b0;
      bus.ALU_EN    <= 1'b0;
      bus.ALU_FUN   <= '0;
      bus.CLK_EN    <= 1'b0;
      bus.TX_P_DATA <= '0;
      bus.TX_D_VLD  <= 1'b0;
    end else begin
      bus.WrEn     <= 1'b0;
      bus.RdEn     <= 1'b0;
      bus.ALU_EN   <= 1'b0;
      bus.TX_D_VLD <= 1'b0;
      case (state)
        IDLE: if (bus.RX_D_VLD) begin
          case (bus.RX_P_DATA)
            OP_WR:   state <= WR_ADDR;
            OP_RD:   state <= RD_ADDR;
            OP_ALU:  state <= OPA;
            OP_FUN:  state <= FUN;
            default: state <= IDLE;
          endcase
        end
        WR_ADDR: if (bus.RX_D_VLD) begin
          bus.ADDR <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
          state    <= WR_DATA;
        end
        WR_DATA: if (bus.RX_D_VLD) begin
          bus.WrData <= bus.RX_P_DATA;
          bus.WrEn   <= 1'b1;
          state      <= IDLE;
        end
        RD_ADDR: if (bus.RX_D_VLD) begin
          bus.ADDR <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
          bus.RdEn <= 1'b1;
          wait_cnt <= '0;
          state    <= RD_WAIT;
        end
        // A valid arriving on the terminal count is still accepted.
        RD_WAIT: if (bus.RdData_Valid) begin
          result      <= {{DATA_WIDTH{1'b0}}, bus.RdData};
          single_byte <= 1'b1;
          state       <= TX_LO;
        end else if (wait_cnt == CNT_LAST) begin
          state <= IDLE;
        end else begin
          wait_cnt <= wait_cnt + CNT_WIDTH'(1);
        end
        OPA: if (bus.RX_D_VLD) begin
          bus.ADDR   <= ADDR_WIDTH'(OPA_ADDR);
          bus.WrData <= bus.RX_P_DATA;
          bus.WrEn   <= 1'b1;
          state      <= OPB;
        end
        OPB: if (bus.RX_D_VLD) begin
          bus.ADDR   <= ADDR_WIDTH'(OPB_ADDR);
          bus.WrData <= bus.RX_P_DATA;
          bus.WrEn   <= 1'b1;
          state      <= FUN;
        end
        FUN: if (bus.RX_D_VLD) begin
          bus.ALU_FUN <= bus.RX_P_DATA[FUN_WIDTH-1:0];
          bus.ALU_EN  <= 1'b1;
          bus.CLK_EN  <= 1'b1;
          wait_cnt    <= '0;
          state       <= ALU_WAIT;
        end
        ALU_WAIT: if (bus.OUT_Valid) begin
          result      <= bus.ALU_OUT;
          single_byte <= 1'b0;
          bus.CLK_EN  <= 1'b0;
          state       <= TX_LO;
        end else if (wait_cnt == CNT_LAST) begin
          bus.CLK_EN <= 1'b0;
          state      <= IDLE;
        end else begin
          wait_cnt <= wait_cnt + CNT_WIDTH'(1);
        end
        TX_LO: if (!bus.FIFO_FULL) begin
          bus.TX_P_DATA <= result[DATA_WIDTH-1:0];
          bus.TX_D_VLD  <= 1'b1;
          state         <= single_byte ? IDLE : TX_HI;
        end
        TX_HI: if (!bus.FIFO_FULL) begin
          bus.TX_P_DATA <= result[2*DATA_WIDTH-1:DATA_WIDTH];
          bus.TX_D_VLD  <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sys_ctrl_rx.sv
// Randomized frame-level bench for sys_ctrl_rx: a register-file/ALU model on the
// bench side predicts writes, reads, ALU starts and TX bytes per frame.
module tb_sys_ctrl_rx;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int FW  = 4;
  localparam int TMO = 255;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  sys_ctrl_rx_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) bus ();

  sys_ctrl_rx #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW),
    .OPA_ADDR(0), .OPB_ADDR(1), .RSP_TIMEOUT(TMO)
  ) dut (.CLK(CLK), .RST(RST), .bus(bus));

  logic [7:0]  rf [16];
  logic [11:0] wr_q[$], exp_wr[$];
  logic [3:0]  rd_q[$], exp_rd[$], alu_q[$], exp_alu[$];
  logic [7:0]  tx_q[$], exp_tx[$];
  int          rd_delay = 0, alu_delay = 0;
  logic [7:0]  rd_val = 8'h00;
  logic [15:0] alu_val = 16'h0000;
  bit          busy = 1'b0, ff_rand = 1'b0, ff_force = 1'b0;
  logic        ff_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Event monitor, sampled on the falling edge
  always @(negedge CLK) begin
    if (RST) begin
      if (bus.WrEn)   wr_q.push_back({bus.ADDR, bus.WrData});
      if (bus.RdEn)   rd_q.push_back(bus.ADDR);
      if (bus.ALU_EN) alu_q.push_back(bus.ALU_FUN);
      if (bus.TX_D_VLD) begin
        tx_q.push_back(bus.TX_P_DATA);
        chk("tx_while_full", 32'(ff_prev), 32'(0));
      end
    end
    ff_prev = bus.FIFO_FULL;
  end

  initial begin
    bus.FIFO_FULL = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      bus.FIFO_FULL = ff_rand ? ($urandom_range(0, 2) == 0) : ff_force;
    end
  end

  // RF / ALU responder; a negative delay means no response at all
  initial begin
    bus.RdData_Valid = 1'b0;
    bus.RdData       = '0;
    bus.OUT_Valid    = 1'b0;
    bus.ALU_OUT      = '0;
    forever begin
      @(negedge CLK);
      if (RST && bus.RdEn) begin
        busy = 1'b1;
        if (rd_delay < 0) repeat (TMO + 3) @(posedge CLK);
        else begin
          if (rd_delay > 0) begin repeat (rd_delay) @(posedge CLK); #1; end
          bus.RdData       = rd_val;
          bus.RdData_Valid = 1'b1;
          @(posedge CLK); #1;
          bus.RdData_Valid = 1'b0;
          bus.RdData       = 8'($urandom);
        end
        busy = 1'b0;
      end else if (RST && bus.ALU_EN) begin
        busy = 1'b1;
        chk("clk_en_start", 32'(bus.CLK_EN), 32'(1));
        if (alu_delay < 0) begin
          repeat (TMO + 3) @(posedge CLK);
          @(negedge CLK);
          chk("clk_en_timeout", 32'(bus.CLK_EN), 32'(0));
        end else begin
          if (alu_delay > 0) begin repeat (alu_delay) @(posedge CLK); #1; end
          bus.ALU_OUT   = alu_val;
          bus.OUT_Valid = 1'b1;
          if (alu_delay > 0) @(negedge CLK);
          chk("clk_en_hold", 32'(bus.CLK_EN), 32'(alu_delay <= TMO));
          @(posedge CLK); #1;
          bus.OUT_Valid = 1'b0;
          bus.ALU_OUT   = 16'($urandom);
          @(negedge CLK);
          chk("clk_en_off", 32'(bus.CLK_EN), 32'(0));
        end
        busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    tick();
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = 8'($urandom);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hAA, $urandom_range(0, 3));
    send_byte(a, $urandom_range(0, 3));
    send_byte(d, $urandom_range(0, 3));
    exp_wr.push_back({a[3:0], d});
    rf[a[3:0]] = d;
  endtask

  task automatic do_read(input logic [7:0] a, input int dly, input bit stray);
    rd_delay = dly;
    rd_val   = rf[a[3:0]];
    send_byte(8'hBB, $urandom_range(0, 3));
    send_byte(a, $urandom_range(0, 3));
    if (stray) send_byte(8'hAA, 0);
    exp_rd.push_back(a[3:0]);
    if (dly >= 0 && dly <= TMO) exp_tx.push_back(rf[a[3:0]]);
  endtask

  task automatic do_alu(input bit with_ops, input logic [7:0] opa, input logic [7:0] opb,
                        input logic [7:0] fun, input int dly, input logic [15:0] res,
                        input bit stray);
    alu_delay = dly;
    alu_val   = res;
    if (with_ops) begin
      send_byte(8'hCC, $urandom_range(0, 3));
      send_byte(opa, $urandom_range(0, 3));
      send_byte(opb, $urandom_range(0, 3));
      exp_wr.push_back({4'd0, opa});
      exp_wr.push_back({4'd1, opb});
      rf[0] = opa;
      rf[1] = opb;
    end else begin
      send_byte(8'hDD, $urandom_range(0, 3));
    end
    send_byte(fun, $urandom_range(0, 3));
    if (stray) send_byte(8'hBB, 0);
    exp_alu.push_back(fun[3:0]);
    if (dly >= 0 && dly <= TMO) begin
      exp_tx.push_back(res[7:0]);
      exp_tx.push_back(res[15:8]);
    end
  endtask

  task automatic finish_frame();
    int budget;
    budget = 3000;
    tick();
    tick();
    while ((busy || tx_q.size() < exp_tx.size()) && budget > 0) begin
      tick();
      budget--;
    end
    chk("frame_settle", 32'(budget > 0), 32'(1));
    repeat (4) tick();
    chk("wr_count", 32'(wr_q.size()), 32'(exp_wr.size()));
    foreach (exp_wr[i]) chk("wr_addr_data", 32'((i < wr_q.size()) ? wr_q[i] : 12'hFFF), 32'(exp_wr[i]));
    chk("rd_count", 32'(rd_q.size()), 32'(exp_rd.size()));
    foreach (exp_rd[i]) chk("rd_addr", 32'((i < rd_q.size()) ? rd_q[i] : 4'hF), 32'(exp_rd[i]));
    chk("alu_count", 32'(alu_q.size()), 32'(exp_alu.size()));
    foreach (exp_alu[i]) chk("alu_fun", 32'((i < alu_q.size()) ? alu_q[i] : 4'hF), 32'(exp_alu[i]));
    chk("tx_count", 32'(tx_q.size()), 32'(exp_tx.size()));
    foreach (exp_tx[i]) chk("tx_byte", 32'((i < tx_q.size()) ? tx_q[i] : 8'hFF), 32'(exp_tx[i]));
    wr_q.delete(); exp_wr.delete(); rd_q.delete(); exp_rd.delete();
    alu_q.delete(); exp_alu.delete(); tx_q.delete(); exp_tx.delete();
  endtask

  task automatic chk_outs_zero(input string tag);
    @(negedge CLK);
    chk(tag, 32'({bus.ADDR, bus.WrEn, bus.WrData, bus.RdEn, bus.ALU_EN, bus.ALU_FUN,
                  bus.CLK_EN, bus.TX_P_DATA, bus.TX_D_VLD}), 32'(0));
  endtask

  initial begin
    int          kind, dly, b;
    logic [7:0]  a, d, f, junk;
    logic [15:0] r;
    bus.RX_P_DATA = '0;
    bus.RX_D_VLD  = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    repeat (3) tick();
    chk_outs_zero("reset_outs");
    RST = 1'b1;
    tick();

    do_write(8'h05, 8'h3C);                          finish_frame();
    do_read(8'h05, 3, 1'b0);                         finish_frame();
    do_alu(1'b1, 8'h10, 8'h20, 8'h00, 2, 16'h0030, 1'b0); finish_frame();

    // FIFO held full across the TX phase
    ff_force = 1'b1;
    do_alu(1'b0, 8'h00, 8'h00, 8'h01, 1, 16'hBEEF, 1'b0);
    b = 500;
    tick(); tick();
    while (busy && b > 0) begin tick(); b--; end
    repeat (10) tick();
    chk("ff_hold_no_tx", 32'(tx_q.size()), 32'(0));
    ff_force = 1'b0;
    finish_frame();

    do_read(8'h05, -1, 1'b0);                        finish_frame();
    do_write(8'h01, 8'hFF);                          finish_frame();
    do_read(8'h13, TMO, 1'b0);                       finish_frame();
    do_read(8'h13, TMO + 1, 1'b0);                   finish_frame();
    do_alu(1'b0, 8'h00, 8'h00, 8'h3A, TMO, 16'h1234, 1'b0);     finish_frame();
    do_alu(1'b0, 8'h00, 8'h00, 8'h3A, TMO + 1, 16'h1234, 1'b0); finish_frame();
    do_alu(1'b0, 8'h00, 8'h00, 8'h07, -1, 16'h5555, 1'b0);      finish_frame();
    do_read(8'h01, 4, 1'b1);                         finish_frame();
    do_alu(1'b1, 8'h77, 8'h88, 8'hF2, 0, 16'hA55A, 1'b1); finish_frame();

    // Reset in the middle of a frame
    send_byte(8'hAA, 1);
    send_byte(8'h05, 1);
    RST = 1'b0;
    chk_outs_zero("midframe_rst_outs");
    tick();
    RST = 1'b1;
    tick();
    send_byte(8'h3C, 1);
    do_write(8'h02, 8'h11);
    finish_frame();

    for (int n = 0; n < 40; n++) begin
      kind    = $urandom_range(0, 4);
      a       = 8'($urandom);
      d       = 8'($urandom);
      f       = 8'($urandom);
      r       = 16'($urandom);
      ff_rand = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       dly = TMO - 1 + $urandom_range(0, 2);
        1:       dly = -1;
        default: dly = $urandom_range(0, 6);
      endcase
      case (kind)
        0: do_write(a, d);
        1: do_read(a, dly, 1'($urandom_range(0, 1)));
        2: do_alu(1'b1, a, d, f, dly, r, 1'($urandom_range(0, 1)));
        3: do_alu(1'b0, a, d, f, dly, r, 1'($urandom_range(0, 1)));
        default: begin
          junk = 8'($urandom);
          if (junk == 8'hAA || junk == 8'hBB || junk == 8'hCC || junk == 8'hDD) junk = 8'h00;
          send_byte(junk, 1);
        end
      endcase
      finish_frame();
    end
    ff_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end
endmodule
